// File: rtl/contact_debouncer.sv
// Debounces a raw contact into a clean level C_DB with one-cycle rise/fall strobes and a saturating glitch count.
// Optional two-flop input synchronizer is compiled in when CONTACT_SYNC_EN is defined.
module contact_debouncer #(
  parameter int DB_CYCLES = 4,
  parameter int CNT_W     = $clog2(DB_CYCLES)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       C_RAW,
  output logic       C_DB,
  output logic       C_RISE,
  output logic       C_FALL,
  output logic [7:0] GLITCH_CNT
);

  typedef enum logic [1:0] {
    STABLE_LO  = 2'd0,
    CONFIRM_HI = 2'd1,
    STABLE_HI  = 2'd2,
    CONFIRM_LO = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic s;

`ifdef CONTACT_SYNC_EN
  logic sync_a;
  logic sync_b;

  // Flops are held at 0 during reset so C_RAW cannot leak into the first post-reset samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_a <= 1'b0;
      sync_b <= 1'b0;
    end else begin
      sync_a <= C_RAW;
      sync_b <= sync_a;
    end
  end

  assign s = sync_b;
`else
  assign s = C_RAW;
`endif

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             db_nxt;
  logic             rise_nxt;
  logic             fall_nxt;
  logic             glitch;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= STABLE_LO;
      cnt        <= '0;
      C_DB       <= 1'b0;
      C_RISE     <= 1'b0;
      C_FALL     <= 1'b0;
      GLITCH_CNT <= 8'd0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      C_DB   <= db_nxt;
      C_RISE <= rise_nxt;
      C_FALL <= fall_nxt;
      if (glitch && (GLITCH_CNT != 8'hFF)) begin
        GLITCH_CNT <= GLITCH_CNT + 8'd1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    db_nxt    = C_DB;
    rise_nxt  = 1'b0;
    fall_nxt  = 1'b0;
    glitch    = 1'b0;
    case (state)
      STABLE_LO: begin
        if (s) begin
          state_nxt = CONFIRM_HI;
          cnt_nxt   = CNT_ONE;
        end
      end
      CONFIRM_HI: begin
        if (!s) begin
          state_nxt = STABLE_LO;
          glitch    = 1'b1;
        end else if (cnt == CNT_LAST) begin
          state_nxt = STABLE_HI;
          db_nxt    = 1'b1;
          rise_nxt  = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      STABLE_HI: begin
        if (!s) begin
          state_nxt = CONFIRM_LO;
          cnt_nxt   = CNT_ONE;
        end
      end
      CONFIRM_LO: begin
        if (s) begin
          state_nxt = STABLE_HI;
          glitch    = 1'b1;
        end else if (cnt == CNT_LAST) begin
          state_nxt = STABLE_LO;
          db_nxt    = 1'b0;
          fall_nxt  = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      default: begin
        state_nxt = STABLE_LO;
      end
    endcase
  end

endmodule

// File: tb/tb_contact_debouncer.sv
// Testbench for contact_debouncer: directed scenarios plus random contact bounce against a run-length reference model.
module tb_contact_debouncer;

  localparam int DB = 4;
`ifdef CONTACT_SYNC_EN
  localparam int SYNC = 2;
`else
  localparam int SYNC = 0;
`endif
  localparam int LAT = DB + SYNC;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       C_RAW = 1'b0;
  logic       C_DB;
  logic       C_RISE;
  logic       C_FALL;
  logic [7:0] GLITCH_CNT;

  contact_debouncer #(.DB_CYCLES(DB)) dut (
    .clk        (clk),
    .rst        (rst),
    .C_RAW      (C_RAW),
    .C_DB       (C_DB),
    .C_RISE     (C_RISE),
    .C_FALL     (C_FALL),
    .GLITCH_CNT (GLITCH_CNT)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: input delay line, then "how long has the sample disagreed with the output".
  bit m_p1, m_p2;
  bit m_db, m_rise, m_fall;
  int m_run;
  int m_gc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    bit s;
    if (rst) begin
      m_p1 = 0; m_p2 = 0; m_db = 0; m_rise = 0; m_fall = 0; m_run = 0; m_gc = 0;
    end else begin
      s = (SYNC > 0) ? m_p2 : C_RAW;
      m_p2 = m_p1;
      m_p1 = C_RAW;
      m_rise = 0;
      m_fall = 0;
      if (s != m_db) begin
        m_run++;
        if (m_run == DB) begin
          m_db   = s;
          m_rise = s;
          m_fall = !s;
          m_run  = 0;
        end
      end else if (m_run > 0) begin
        if (m_gc < 255) m_gc++;
        m_run = 0;
      end
    end
  endtask

  task automatic step(input logic raw, input logic r);
    @(negedge clk);
    C_RAW = raw;
    rst   = r;
    @(posedge clk);
    model_edge();
    #1;
    check("c_db",       C_DB,       m_db);
    check("c_rise",     C_RISE,     m_rise);
    check("c_fall",     C_FALL,     m_fall);
    check("glitch_cnt", GLITCH_CNT, m_gc);
    check("strobe_excl", C_RISE & C_FALL, 0);
  endtask

  // Holds C_RAW at raw and returns the edge number (1-based) at which C_DB reaches want, or -1.
  task automatic hold_until(input logic raw, input logic want, output int edges);
    edges = -1;
    for (int i = 1; i <= 20; i++) begin
      step(raw, 1'b0);
      if (C_DB === want) begin
        edges = i;
        break;
      end
    end
  endtask

  initial begin
    int   e;
    logic lvl;
    int   len;
    int   cyc;

    // Reset held with contact closed.
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1);
      check("rst_db",     C_DB,       0);
      check("rst_strobe", C_RISE | C_FALL, 0);
      check("rst_gcnt",   GLITCH_CNT, 0);
    end
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0);

    // Clean rise.
    hold_until(1'b1, 1'b1, e);
    check("rise_latency", e, LAT);
    check("rise_strobe", C_RISE, 1);
    step(1'b1, 1'b0);
    check("rise_one_cycle", C_RISE, 0);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0);
    check("clean_fall_db", C_DB, 0);
    check("no_glitch_yet", GLITCH_CNT, 0);

    // Two-cycle high glitch from stable low.
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b0);
      check("glitch_db_low", C_DB, 0);
      check("glitch_no_rise", C_RISE, 0);
    end
    check("glitch_cnt_1", GLITCH_CNT, 1);

    // From stable high: low 3, high 1, then low held.
    hold_until(1'b1, 1'b1, e);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    hold_until(1'b0, 1'b0, e);
    check("fall_latency", e, LAT);
    check("fall_strobe", C_FALL, 1);
    check("glitch_cnt_2", GLITCH_CNT, 2);
    step(1'b0, 1'b0);
    check("fall_one_cycle", C_FALL, 0);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0);

    // Saturation.
    for (int k = 0; k < 300; k++) begin
      step(1'b1, 1'b0);
      step(1'b1, 1'b0);
      step(1'b0, 1'b0);
      step(1'b0, 1'b0);
    end
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0);
    check("glitch_saturate", GLITCH_CNT, 255);
    check("saturate_db", C_DB, 0);

    // Reset while confirming high at cnt=2.
    for (int i = 0; i < SYNC + 2; i++) step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    check("midrst_db", C_DB, 0);
    check("midrst_rise", C_RISE, 0);
    check("midrst_gcnt", GLITCH_CNT, 0);
    hold_until(1'b1, 1'b1, e);
    check("post_rst_latency", e, LAT);

    // Random bounce with occasional resets.
    lvl = 1'b1;
    cyc = 0;
    while (cyc < 3000) begin
      len = $urandom_range(1, 7);
      lvl = ~lvl;
      for (int i = 0; i < len; i++) begin
        step(lvl, ($urandom_range(0, 199) == 0));
        cyc++;
      end
    end
    step(1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/contact_debouncer.md
# contact_debouncer

- Debounces the raw door/window contact and produces the clean level `C_DB` consumed by the start driver, plus one-cycle edge strobes.
- A contact change is accepted only after it has been stable for a programmable number of consecutive clock cycles; shorter glitches are discarded and counted.
- Sits between the board contact pin and the start/run control logic.

## Interface

Parameters:
- `DB_CYCLES`, 4: consecutive stable samples required to accept a change; legal range 2..65535.
- `CNT_W`, `$clog2(DB_CYCLES)`: derived width of the stability counter; not overridden.

Ports:
- `clk`, input, 1: system clock; the only clock.
- `rst`, input, 1: reset, synchronous and active-high.
- `C_RAW`, input, 1: raw contact, asynchronous to `clk`; 1 = closed.
- `C_DB`, output, 1: debounced contact level; feeds the start driver.
- `C_RISE`, output, 1: one-cycle strobe when `C_DB` goes 0->1.
- `C_FALL`, output, 1: one-cycle strobe when `C_DB` goes 1->0.
- `GLITCH_CNT`, output, 8: saturating count of rejected transitions.

## Operation

- Sampled input `s`:
  - With the synchronizer compiled in, `s` is `C_RAW` after two flops.
  - Otherwise `s` is `C_RAW` directly.
- FSM has 4 states; `cnt` is a `CNT_W`-bit counter.
  - `STABLE_LO`, `C_DB`=0:
    - `s`=1 -> `CONFIRM_HI`, `cnt`<=1.
    - Otherwise stay.
  - `CONFIRM_HI`, `C_DB`=0:
    - `s`=0 -> `STABLE_LO`, `GLITCH_CNT`++.
    - `s`=1 and `cnt`==`DB_CYCLES`-1 -> `STABLE_HI`, `C_DB`<=1, `C_RISE`<=1.
    - Otherwise `cnt`++.
  - `STABLE_HI`, `C_DB`=1:
    - `s`=0 -> `CONFIRM_LO`, `cnt`<=1.
  - `CONFIRM_LO`, `C_DB`=1:
    - `s`=1 -> `STABLE_HI`, `GLITCH_CNT`++.
    - `s`=0 and `cnt`==`DB_CYCLES`-1 -> `STABLE_LO`, `C_DB`<=0, `C_FALL`<=1.
    - Otherwise `cnt`++.
- `C_RISE`/`C_FALL` are registered and high for exactly one cycle. They are never high together.
- `GLITCH_CNT` saturates at 255 and never wraps. It is cleared only by `rst`.
- `cnt` never exceeds `DB_CYCLES`-1. No wrap is possible.

## Timing

- Reset values:
  - State `STABLE_LO`.
  - `C_DB`=0, `C_RISE`=0, `C_FALL`=0.
  - `GLITCH_CNT`=0, `cnt`=0.
  - Synchronizer flops 0.
- Latency from the first edge that samples the new `C_RAW` value to `C_DB` updated:
  - `DB_CYCLES`+2 edges with the synchronizer.
  - `DB_CYCLES` edges without it.
- `C_RISE`/`C_FALL` assert on the same edge that `C_DB` changes.
- Glitch boundary: a level held for `DB_CYCLES`-1 samples, then reverting, is rejected (`GLITCH_CNT`+1). Held for `DB_CYCLES` samples, it is accepted.
- A glitch that reverts increments `GLITCH_CNT` on the edge the revert is sampled. `C_DB` is unaffected.
- Reset mid-confirm: the pending change is discarded, no strobe fires, outputs take their reset values next edge.
- Reset has priority over all transitions on the same edge.
- While `rst`=1, `C_RAW` is ignored, including by the synchronizer flops.

## Configuration

- `CONTACT_SYNC_EN`:
  - Defined: two-flop synchronizer on `C_RAW`; latency `DB_CYCLES`+2.
  - Undefined: `C_RAW` feeds the FSM directly; latency `DB_CYCLES`. Only for sources already synchronous to `clk`.
- All other behaviour is identical in both builds.

## Test plan

All scenarios use `DB_CYCLES`=4, `CONTACT_SYNC_EN` defined, 10 ns clock.

- Reset held 3 cycles with `C_RAW`=1 -> `C_DB`=0, strobes 0, `GLITCH_CNT`=0 throughout reset.
- After reset, `C_RAW` 0->1 and held -> `C_DB`=1 and `C_RISE` pulse exactly 6 edges later. `C_RISE` high 1 cycle only.
- `C_RAW` high for 2 cycles then low, from stable low -> `C_DB` stays 0, no `C_RISE`, `GLITCH_CNT`=1.
- From stable high, `C_RAW` low 3 cycles, high 1, then low held -> `GLITCH_CNT` increments once. `C_FALL` fires 6 edges after the final fall.
- 300 two-cycle glitches -> `GLITCH_CNT` saturates at 255. `C_DB` unchanged.
- `rst` pulsed during `CONFIRM_HI` (`cnt`=2) -> no `C_RISE`, `C_DB`=0. A fresh 6-edge confirm is required after release.
